// File: rtl/coord_uart_tx_if.sv
// Coordinate strobe input and UART line outputs of coord_uart_tx.
// The master side (the image processing unit) drives the coordinate strobe;
// the slave side (the serializer) drives the TX line and the status flags.
interface coord_uart_tx_if;
  logic [10:0] iRow;
  logic [10:0] iCol;
  logic        iDVAL;
  logic        oTX;
  logic        oBUSY;
  logic        oOVERFLOW;

  modport master (
    output iRow, iCol, iDVAL,
    input  oTX, oBUSY, oOVERFLOW
  );

  modport slave (
    input  iRow, iCol, iDVAL,
    output oTX, oBUSY, oOVERFLOW
  );
endinterface

// File: rtl/coord_uart_tx.sv
// Coordinate-to-UART serializer: buffers {row, col} strobes in a small FIFO
// and sends each one as a 5-byte 8N1 packet (A5, row hi, row lo, col hi, col lo).
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | line high; pops the FIFO head when one is waiting
//   START | start bit (low) for one bit period
//   DATA  | 8 data bits of the current byte, LSB first
//   STOP  | stop bit (high); next byte or back to IDLE after byte 4
//
// The line and busy flops are driven from the current state, so oTX lags the
// FSM by one cycle; every bit still lasts exactly DIV cycles on the pin.
module coord_uart_tx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input logic            iCLK,
  input logic            iRST,
  coord_uart_tx_if.slave bus
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] BAUD_RELOAD = CW'(DIV - 1);
  localparam logic [AW:0]   FULL_CNT    = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // FIFO storage and pointers
  logic [21:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  // serializer state
  state_t        r_state;
  logic [CW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [2:0]    r_byte;
  logic [21:0]   r_hold;
  logic          r_tx;
  logic          r_busy;
  logic          r_ovf;

  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_tc;
  logic [7:0]    w_cur_byte;
  state_t        w_state_nx;
  logic [CW-1:0] w_baud_nx;
  logic [2:0]    w_bit_nx;
  logic [2:0]    w_byte_nx;
  logic          w_tx_nx;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  // IDLE pops whenever something is waiting; that pop frees a slot this same
  // cycle, so a strobe arriving at full is still accepted
  assign w_pop   = (r_state == IDLE) && !w_empty;
  assign w_push  = bus.iDVAL && (!w_full || w_pop);
  assign w_drop  = bus.iDVAL && !w_push;
  assign w_tc    = (r_baud == '0);

  // FIFO data array; contents need no reset since the count gates every read
  always_ff @(posedge iCLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {bus.iRow, bus.iCol};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // byte currently being framed, selected by the byte index
  always_comb begin
    w_cur_byte = 8'hA5;
    case (r_byte)
      3'd0:    w_cur_byte = 8'hA5;
      3'd1:    w_cur_byte = {5'b0, r_hold[21:19]};
      3'd2:    w_cur_byte = r_hold[18:11];
      3'd3:    w_cur_byte = {5'b0, r_hold[10:8]};
      default: w_cur_byte = r_hold[7:0];
    endcase
  end

  // next-state, baud down-counter and line level for the current state
  always_comb begin
    w_state_nx = r_state;
    w_baud_nx  = r_baud;
    w_bit_nx   = r_bit;
    w_byte_nx  = r_byte;
    w_tx_nx    = 1'b1;
    case (r_state)
      IDLE: begin
        w_tx_nx = 1'b1;
        if (!w_empty) begin
          w_state_nx = START;
          w_baud_nx  = BAUD_RELOAD;
          w_byte_nx  = 3'd0;
          w_bit_nx   = 3'd0;
        end
      end
      START: begin
        w_tx_nx = 1'b0;
        if (w_tc) begin
          w_state_nx = DATA;
          w_baud_nx  = BAUD_RELOAD;
          w_bit_nx   = 3'd0;
        end else begin
          w_baud_nx = r_baud - 1'b1;
        end
      end
      DATA: begin
        w_tx_nx = w_cur_byte[r_bit];
        if (w_tc) begin
          w_baud_nx = BAUD_RELOAD;
          if (r_bit == 3'd7) begin
            w_state_nx = STOP;
          end else begin
            w_bit_nx = r_bit + 1'b1;
          end
        end else begin
          w_baud_nx = r_baud - 1'b1;
        end
      end
      STOP: begin
        w_tx_nx = 1'b1;
        if (w_tc) begin
          if (r_byte == 3'd4) begin
            w_state_nx = IDLE;
            w_baud_nx  = '0;
          end else begin
            w_state_nx = START;
            w_byte_nx  = r_byte + 1'b1;
            w_baud_nx  = BAUD_RELOAD;
          end
        end else begin
          w_baud_nx = r_baud - 1'b1;
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_baud_nx  = '0;
      end
    endcase
  end

  // FSM registers, hold register and registered outputs
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_hold  <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_baud  <= w_baud_nx;
      r_bit   <= w_bit_nx;
      r_byte  <= w_byte_nx;
      if (w_pop) begin
        r_hold <= r_mem[r_rd_ptr];
      end
      r_tx    <= w_tx_nx;
      r_busy  <= (r_state != IDLE) || (r_count != '0);
      r_ovf   <= w_drop;
    end
  end

  assign bus.oTX       = r_tx;
  assign bus.oBUSY     = r_busy;
  assign bus.oOVERFLOW = r_ovf;

endmodule

// File: tb/tb_coord_uart_tx.sv
// Directed bench for coord_uart_tx with DIV=8 and a 4-entry FIFO.
// A line decoder samples oTX on falling clock edges and rebuilds packets.
module tb_coord_uart_tx;

  localparam int CLK_FREQ = 80;
  localparam int BAUD     = 10;
  localparam int DEPTH    = 4;

  logic iCLK = 1'b0;
  logic iRST;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  coord_uart_tx_if bus ();

  coord_uart_tx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .iCLK(iCLK),
    .iRST(iRST),
    .bus (bus)
  );

  always #5 iCLK = ~iCLK;

  always @(posedge iCLK) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [39:0] exp_pkt(input logic [10:0] r, input logic [10:0] c);
    return {8'hA5, 5'b0, r[10:8], r[7:0], 5'b0, c[10:8], c[7:0]};
  endfunction

  // Waits up to 'limit' falling edges for a start bit, then samples 400
  // cycles: each bit must hold for 8 samples, start low, stop high.
  // Returns at the falling edge carrying the last stop-bit sample.
  task automatic rx_packet(input int limit, output logic [39:0] pkt, output int t_fall,
                           output int bad, output bit tmo);
    int  n;
    logic v;
    pkt = '0; bad = 0; tmo = 1'b0; t_fall = 0; n = 0;
    while (bus.oTX !== 1'b0 && n < limit) begin
      @(negedge iCLK);
      n++;
    end
    if (bus.oTX !== 1'b0) begin
      tmo = 1'b1;
      return;
    end
    t_fall = cyc;
    for (int b = 0; b < 5; b++) begin
      for (int k = 0; k < 10; k++) begin
        for (int s = 0; s < 8; s++) begin
          if (!(b == 0 && k == 0 && s == 0)) @(negedge iCLK);
          v = bus.oTX;
          if (k == 0) begin
            if (v !== 1'b0) bad++;
          end else if (k == 9) begin
            if (v !== 1'b1) bad++;
          end else if (s == 0) begin
            pkt[32 - 8*b + k - 1] = v;
          end else if (v !== pkt[32 - 8*b + k - 1]) begin
            bad++;
          end
        end
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (bus.oBUSY !== 1'b0 && n < 3000) begin
      @(negedge iCLK);
      n++;
    end
    check_eq(tag, bus.oBUSY, 1'b0);
  endtask

  logic [39:0] pk [6];
  int          tf [6];
  int          bd [6];
  bit          tm [6];
  logic [39:0] p_tmp;
  int          t_tmp, b_tmp, k0, wn, bad;
  bit          m_tmp;
  logic [5:0]  ovf_seen;
  logic        ovf_after;
  logic [10:0] fr [5];
  logic [10:0] fc [5];

  initial begin
    bus.iDVAL = 1'b0;
    bus.iRow  = '0;
    bus.iCol  = '0;
    iRST      = 1'b0;

    // reset before any clock edge
    #1 iRST = 1'b1;
    #1;
    check_eq("rst_tx", bus.oTX, 1'b1);
    check_eq("rst_busy", bus.oBUSY, 1'b0);
    check_eq("rst_ovf", bus.oOVERFLOW, 1'b0);
    repeat (3) @(negedge iCLK);
    iRST = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge iCLK);
      if (bus.oTX !== 1'b1 || bus.oBUSY !== 1'b0 || bus.oOVERFLOW !== 1'b0) bad++;
    end
    check_eq("post_rst_quiet", bad, 0);

    // single packet
    fork
      begin
        @(negedge iCLK);
        bus.iRow = 11'h2A5; bus.iCol = 11'h13C; bus.iDVAL = 1'b1;
        k0 = cyc + 1;
        @(negedge iCLK);
        bus.iDVAL = 1'b0;
      end
      rx_packet(50, pk[0], tf[0], bd[0], tm[0]);
    join
    check_eq("single_tmo", tm[0], 1'b0);
    check_eq("single_bytes", pk[0], 40'hA5_02_A5_01_3C);
    check_eq("single_latency", tf[0] - k0, 2);
    check_eq("single_bits", bd[0], 0);
    check_eq("busy_last_stop", bus.oBUSY, 1'b1);
    @(negedge iCLK);
    check_eq("busy_fall", bus.oBUSY, 1'b0);
    check_eq("busy_fall_at", cyc - tf[0], 400);

    // extreme values back to back
    fork
      begin
        @(negedge iCLK);
        bus.iRow = 11'h7FF; bus.iCol = 11'h7FF; bus.iDVAL = 1'b1;
        @(negedge iCLK);
        bus.iRow = 11'h000; bus.iCol = 11'h000;
        @(negedge iCLK);
        bus.iDVAL = 1'b0;
      end
      begin
        rx_packet(50, pk[0], tf[0], bd[0], tm[0]);
        rx_packet(50, pk[1], tf[1], bd[1], tm[1]);
      end
    join
    check_eq("ext_tmo", {tm[0], tm[1]}, 2'b00);
    check_eq("ext_max", pk[0], 40'hA5_07_FF_07_FF);
    check_eq("ext_zero", pk[1], 40'hA5_00_00_00_00);
    check_eq("ext_spacing", tf[1] - tf[0], 401);
    check_eq("ext_bits", bd[0] + bd[1], 0);
    wait_idle("ext_idle");

    // overflow: six strobes in a row
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          @(negedge iCLK);
          if (i > 0) ovf_seen[i-1] = bus.oOVERFLOW;
          bus.iRow = 11'(i + 1); bus.iCol = 11'(i + 1); bus.iDVAL = 1'b1;
        end
        @(negedge iCLK);
        ovf_seen[5] = bus.oOVERFLOW;
        bus.iDVAL = 1'b0;
        @(negedge iCLK);
        ovf_after = bus.oOVERFLOW;
      end
      begin
        for (int j = 0; j < 5; j++) begin
          rx_packet(50, p_tmp, t_tmp, b_tmp, m_tmp);
          pk[j] = p_tmp; bd[j] = b_tmp; tm[j] = m_tmp;
        end
        rx_packet(600, p_tmp, t_tmp, b_tmp, m_tmp);
        tm[5] = m_tmp;
      end
    join
    check_eq("ovf_pulse", ovf_seen, 6'b100000);
    check_eq("ovf_after", ovf_after, 1'b0);
    for (int j = 0; j < 5; j++) begin
      check_eq($sformatf("ovf_pkt%0d", j), pk[j], exp_pkt(11'(j + 1), 11'(j + 1)));
      check_eq($sformatf("ovf_bits%0d", j), bd[j] + int'(tm[j]), 0);
    end
    check_eq("ovf_dropped_not_sent", tm[5], 1'b1);
    wait_idle("ovf_idle");

    // reset during data bit 3 of byte 2, with a second entry buffered
    @(negedge iCLK);
    bus.iRow = 11'h2A5; bus.iCol = 11'h13C; bus.iDVAL = 1'b1;
    k0 = cyc + 1;
    @(negedge iCLK);
    bus.iRow = 11'h123; bus.iCol = 11'h456;
    @(negedge iCLK);
    bus.iDVAL = 1'b0;
    wn = 0;
    while (cyc < k0 + 2 + 195 && wn < 1000) begin
      @(negedge iCLK);
      wn++;
    end
    check_eq("mid_bit_level", bus.oTX, 1'b0);
    check_eq("mid_busy", bus.oBUSY, 1'b1);
    #1 iRST = 1'b1;
    #1;
    check_eq("mid_rst_tx", bus.oTX, 1'b1);
    check_eq("mid_rst_busy", bus.oBUSY, 1'b0);
    repeat (2) @(negedge iCLK);
    iRST = 1'b0;
    rx_packet(600, p_tmp, t_tmp, b_tmp, m_tmp);
    check_eq("mid_no_more_bits", m_tmp, 1'b1);
    check_eq("mid_busy_after", bus.oBUSY, 1'b0);
    fork
      begin
        @(negedge iCLK);
        bus.iRow = 11'h555; bus.iCol = 11'h0AA; bus.iDVAL = 1'b1;
        k0 = cyc + 1;
        @(negedge iCLK);
        bus.iDVAL = 1'b0;
      end
      rx_packet(50, pk[0], tf[0], bd[0], tm[0]);
    join
    check_eq("mid_new_pkt", pk[0], 40'hA5_05_55_00_AA);
    check_eq("mid_new_latency", tf[0] - k0, 2);
    check_eq("mid_new_bits", bd[0] + int'(tm[0]), 0);
    wait_idle("mid_idle");

    // push at full coinciding with the IDLE pop
    fr[0] = 11'h010; fc[0] = 11'h020;
    fr[1] = 11'h101; fc[1] = 11'h702;
    fr[2] = 11'h203; fc[2] = 11'h604;
    fr[3] = 11'h305; fc[3] = 11'h506;
    fr[4] = 11'h407; fc[4] = 11'h408;
    fork
      begin
        @(negedge iCLK);
        bus.iRow = fr[0]; bus.iCol = fc[0]; bus.iDVAL = 1'b1;
        k0 = cyc + 1;
        @(negedge iCLK);
        bus.iDVAL = 1'b0;
        repeat (3) @(negedge iCLK);
        bad = 0;
        for (int i = 1; i < 5; i++) begin
          @(negedge iCLK);
          if (bus.oOVERFLOW !== 1'b0) bad++;
          bus.iRow = fr[i]; bus.iCol = fc[i]; bus.iDVAL = 1'b1;
        end
        @(negedge iCLK);
        if (bus.oOVERFLOW !== 1'b0) bad++;
        bus.iDVAL = 1'b0;
        wn = 0;
        while (cyc < k0 + 401 && wn < 1000) begin
          @(negedge iCLK);
          wn++;
        end
        bus.iRow = 11'h6AB; bus.iCol = 11'h1CD; bus.iDVAL = 1'b1;
        @(negedge iCLK);
        ovf_after = bus.oOVERFLOW;
        bus.iDVAL = 1'b0;
      end
      begin
        for (int j = 0; j < 6; j++) begin
          rx_packet(50, p_tmp, t_tmp, b_tmp, m_tmp);
          pk[j] = p_tmp; bd[j] = b_tmp; tm[j] = m_tmp;
        end
      end
    join
    check_eq("pp_fill_no_ovf", bad, 0);
    check_eq("pp_no_ovf", ovf_after, 1'b0);
    for (int j = 0; j < 5; j++) begin
      check_eq($sformatf("pp_pkt%0d", j), pk[j], exp_pkt(fr[j], fc[j]));
    end
    check_eq("pp_pkt5", pk[5], 40'hA5_06_AB_01_CD);
    check_eq("pp_bits", bd[0] + bd[1] + bd[2] + bd[3] + bd[4] + bd[5], 0);
    check_eq("pp_tmo", {tm[0], tm[1], tm[2], tm[3], tm[4], tm[5]}, 6'b0);
    wait_idle("pp_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/coord_uart_tx.md
# coord_uart_tx

Serializes detected-object coordinates from the image processing unit onto a UART line for the host link. It accepts single-cycle coordinate strobes (row, column, valid), buffers them in a small FIFO, and transmits each coordinate as a 5-byte framed packet in 8N1 format. It sits downstream of the image processing unit's row/column/valid output and drives the board TX pin.

## Interface
Parameters:
- CLK_FREQ, 50_000_000: iCLK frequency in Hz.
- BAUD, 115200: line rate. Bit period DIV = CLK_FREQ/BAUD, integer-truncated. DIV must be at least 2.
- FIFO_DEPTH, 4: number of coordinate entries. Must be a power of 2 and at least 2.

Ports:
- iCLK  in  1  system clock; all logic is on the rising edge.
- iRST  in  1  reset; asynchronous, active-high.
- iRow  in  11  coordinate row; sampled when iDVAL=1.
- iCol  in  11  coordinate column; sampled when iDVAL=1.
- iDVAL  in  1  one-cycle strobe marking a valid coordinate.
- oTX  out  1  UART serial output; idle high.
- oBUSY  out  1  high while the FIFO is non-empty or a packet is in flight.
- oOVERFLOW  out  1  one-cycle pulse when a coordinate is dropped.

## Operation
- **FIFO.** Entries are 22 bits, {row, col}.
  - Push on any cycle with iDVAL=1 when not full. A push at full is also accepted if a pop occurs in the same cycle.
  - Otherwise an iDVAL at full drops the new coordinate (oldest data is kept) and oOVERFLOW=1 for that cycle.
  - Pointers wrap modulo FIFO_DEPTH. The count saturates correctly under simultaneous push and pop.
- **Packet byte order.** Sent in this order:
  - B0 = 0xA5
  - B1 = {5'b0, row[10:8]}
  - B2 = row[7:0]
  - B3 = {5'b0, col[10:8]}
  - B4 = col[7:0]
- **Byte framing.** Each byte is sent as a start bit (0), then data bits LSB first, then a stop bit (1). Every bit lasts exactly DIV cycles.
- **FSM states:** IDLE, START, DATA, STOP. Registers: byte index 0..4, bit index 0..7, baud counter 0..DIV-1.
  - IDLE: oTX=1. If the FIFO is non-empty, pop the head into the 22-bit shift/hold register, set byte index to 0, and go to START.
  - START: oTX=0 for DIV cycles, then go to DATA with bit index 0.
  - DATA: oTX = current byte[bit]. After DIV cycles, advance the bit. After bit 7, go to STOP.
  - STOP: oTX=1 for DIV cycles. Then:
    - if byte index < 4, increment it and go to START (no gap between bytes);
    - otherwise go to IDLE.
- **Packet spacing.** IDLE always lasts at least one cycle between packets. This adds exactly 1 extra idle-high cycle between back-to-back packets.
- **oBUSY.** oBUSY = (state != IDLE) | (count != 0). It is registered alongside state.
- **Drive.** oTX is driven from a flop.
- **Reset.**
  - Outputs on reset: oTX=1, oBUSY=0, oOVERFLOW=0.
  - Internal state on reset: FIFO empty, FSM IDLE, all counters 0.
  - Assertion mid-packet forces oTX high immediately (asynchronously) and abandons the packet. Buffered entries are discarded.

## Timing
- An iDVAL sampled at edge k with an idle, empty block is written at edge k and popped at edge k+1. oTX falls (start bit) after edge k+2.
- Packet duration: 5 bytes × 10 bits × DIV = 50·DIV cycles from the start-bit fall to the end of the last stop bit.
- Back-to-back packets: start-bit falls are 50·DIV+1 cycles apart.
- oOVERFLOW is asserted in the same cycle as the dropped iDVAL (registered output, visible after that edge). One pulse is produced per dropped strobe.
- oBUSY falls one cycle after the final stop bit completes with an empty FIFO.
- Maximum sustained throughput: 1 coordinate per 50·DIV+1 cycles. Strobe bursts beyond FIFO_DEPTH+1 entries (one entry is in flight) are dropped.

## Test plan
Bench parameters: CLK_FREQ=80, BAUD=10 (DIV=8), FIFO_DEPTH=4.
- **Reset values.** Assert iRST with no clock edges. Required: oTX=1, oBUSY=0, oOVERFLOW=0. Release reset with iDVAL=0 for 100 cycles. Required: outputs unchanged.
- **Single packet.** Pulse iDVAL with row=0x2A5, col=0x13C. Required:
  - start bit begins 2 cycles later;
  - decoded bytes A5, 02, A5, 01, 3C;
  - every bit is exactly 8 cycles;
  - total 400 cycles;
  - oBUSY falls 1 cycle after the last stop bit.
- **Extreme values.** Row=0x7FF, col=0x7FF, then row=0, col=0. Required: bytes A5,07,FF,07,FF, then A5,00,00,00,00. The packets are separated by exactly 1 extra idle-high cycle.
- **Overflow.** Drive 6 consecutive iDVAL cycles with coordinates (1,1)…(6,6). Required:
  - oOVERFLOW is high only on the 6th cycle;
  - packets for (1,1)…(5,5) are sent in order;
  - (6,6) is never sent.
- **Reset mid-byte.** Assert iRST during DATA bit 3 of B2. Required:
  - oTX=1 at once;
  - after release, no further bits are sent;
  - a new iDVAL yields a complete, correct packet.
- **Push/pop at full.** Fill the FIFO while a packet is in flight. Strobe iDVAL in the exact cycle IDLE pops. Required: the strobe is accepted, with no oOVERFLOW.
